// File: rtl/joy_sio.sv
// joy_sio: byte-wide serial engine for the PSX controller / memory-card port.
// Exchanges one command byte for one response byte (LSB first, full duplex),
// then waits a bounded time for the device's active-low ACK pulse.
module joy_sio #(
    parameter int HALF_DIV    = 66,
    parameter int ACK_TIMEOUT = 3300,
    parameter int ATT_SETUP   = 66
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       att_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       ack_seen,
    output logic       busy,
    output logic       joy_clk,
    output logic       joy_cmd,
    output logic       joy_att,
    input  logic       joy_data,
    input  logic       joy_ack
);

    localparam int DIV_MAX = (HALF_DIV > ATT_SETUP) ? HALF_DIV : ATT_SETUP;
    localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(HALF_DIV - 1);
    localparam logic [DIV_W-1:0] SETUP_LAST = DIV_W'(ATT_SETUP - 1);
    localparam logic [ACK_W-1:0] ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
    logic [ACK_W-1:0]   ack_cnt_reg, ack_cnt_next;
    logic [3:0]         bit_cnt_reg, bit_cnt_next;
    logic [7:0]         tx_shift_reg, tx_shift_next;
    logic [7:0]         rx_shift_reg, rx_shift_next;
    logic               ack_hit;

    logic [7:0]         rx_data_reg;
    logic               rx_valid_reg;
    logic               ack_seen_reg;
    logic               joy_clk_reg;
    logic               joy_cmd_reg;
    logic               joy_att_reg;

    logic               handshake;
    logic               data_sync;
    logic               ack_sync;

    // Asynchronous pad inputs: bit 0 = joy_data, bit 1 = joy_ack (both idle high)
    logic [1:0]         async_in;
    logic [1:0]         sync_out;

    assign async_in = {joy_ack, joy_data};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;

            // Two-flop synchroniser, preset high so reset looks like an idle line
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg <= 1'b1;
                    s2_reg <= 1'b1;
                end else begin
                    s1_reg <= async_in[gi];
                    s2_reg <= s1_reg;
                end
            end

            assign sync_out[gi] = s2_reg;
        end
    endgenerate

    assign data_sync = sync_out[0];
    assign ack_sync  = sync_out[1];

    assign tx_ready  = (state_reg == ST_IDLE) & att_en;
    assign handshake = tx_valid & tx_ready;
    assign busy      = (state_reg != ST_IDLE);

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign ack_seen  = ack_seen_reg;
    assign joy_clk   = joy_clk_reg;
    assign joy_cmd   = joy_cmd_reg;
    assign joy_att   = joy_att_reg;

    // Next-state, counter and shift-register logic
    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        ack_cnt_next  = ack_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        ack_hit       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    tx_shift_next = tx_data;
                    rx_shift_next = 8'h00;
                    bit_cnt_next  = 4'd0;
                    // Attention still high means this opens a new transaction
                    state_next    = joy_att_reg ? ST_SETUP : ST_SHIFT_LO;
                end
            end
            ST_SETUP: begin
                div_cnt_next = div_cnt_reg + 1'b1;
                if (div_cnt_reg == SETUP_LAST) begin
                    state_next = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                div_cnt_next = div_cnt_reg + 1'b1;
                if (div_cnt_reg == HALF_LAST) begin
                    state_next = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                div_cnt_next = div_cnt_reg + 1'b1;
                if (div_cnt_reg == HALF_LAST) begin
                    rx_shift_next = {data_sync, rx_shift_reg[7:1]};
                    bit_cnt_next  = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd7) begin
                        state_next = ST_WAIT_ACK;
                    end else begin
                        tx_shift_next = {1'b1, tx_shift_reg[7:1]};
                        state_next    = ST_SHIFT_LO;
                    end
                end
            end
            ST_WAIT_ACK: begin
                ack_cnt_next = ack_cnt_reg + 1'b1;
                // ACK is checked first so it wins a tie with the timeout
                if (!ack_sync) begin
                    ack_hit    = 1'b1;
                    state_next = ST_DONE;
                end else if (ack_cnt_reg == ACK_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Every state starts counting from zero
        if (state_next != state_reg) begin
            div_cnt_next = '0;
            ack_cnt_next = '0;
        end
    end

    // State, counters and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            div_cnt_reg  <= '0;
            ack_cnt_reg  <= '0;
            bit_cnt_reg  <= 4'd0;
            tx_shift_reg <= 8'h00;
            rx_shift_reg <= 8'h00;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            ack_cnt_reg  <= ack_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    // Registered pin and host outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            joy_clk_reg  <= 1'b1;
            joy_cmd_reg  <= 1'b1;
            joy_att_reg  <= 1'b1;
            rx_data_reg  <= 8'h00;
            rx_valid_reg <= 1'b0;
            ack_seen_reg <= 1'b0;
        end else begin
            joy_clk_reg  <= (state_next != ST_SHIFT_LO);
            // Command bit only changes on joy_clk falling edges
            joy_cmd_reg  <= ((state_next == ST_SHIFT_LO) || (state_next == ST_SHIFT_HI))
                            ? tx_shift_next[0] : 1'b1;
            joy_att_reg  <= (state_next == ST_IDLE) ? ~att_en : 1'b0;
            rx_valid_reg <= (state_next == ST_DONE);
            ack_seen_reg <= (state_next == ST_DONE) & ack_hit;
            if (state_next == ST_DONE) begin
                rx_data_reg <= rx_shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_joy_sio.sv
// tb_joy_sio: table-driven byte exchanges against a PSX device model, with a
// scoreboard of expected responses and completion cycles, plus hand-written
// sequences for attention drop and mid-byte reset.
module tb_joy_sio;

    localparam int HALF_DIV    = 66;
    localparam int ACK_TIMEOUT = 3300;
    localparam int ATT_SETUP   = 66;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       att_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ack_seen;
    logic       busy;
    logic       joy_clk;
    logic       joy_cmd;
    logic       joy_att;
    logic       joy_data = 1'b1;
    logic       joy_ack;

    joy_sio #(
        .HALF_DIV   (HALF_DIV),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .ATT_SETUP  (ATT_SETUP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .att_en  (att_en),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .ack_seen(ack_seen),
        .busy    (busy),
        .joy_clk (joy_clk),
        .joy_cmd (joy_cmd),
        .joy_att (joy_att),
        .joy_data(joy_data),
        .joy_ack (joy_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        int         edge_n;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] reply;
        int         ack_k;    // WAIT_ACK cycle in which synced ACK is low; -1 = none
        bit         setup;    // first byte of a transaction
        bit         early;    // extra ACK pulse during bit 5
        logic       exp_ack;
    } vec_t;

    vec_t vecs[6];
    int   last_done = 0;

    // Device model: presents reply bits on falling joy_clk, captures cmd on rising
    logic [7:0] dev_reply = 8'h00;
    logic [7:0] dev_cmd   = 8'h00;
    logic [2:0] dev_bit   = 3'd0;

    always @(posedge joy_clk or negedge joy_clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_bit = 3'd0;
        end else if (!joy_clk) begin
            joy_data = dev_reply[dev_bit];
        end else begin
            dev_cmd[dev_bit] = joy_cmd;
            dev_bit = dev_bit + 3'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: compare every rx_valid pulse with the oldest expectation
    always @(negedge clk) begin
        if (rx_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rx_data", rx_data, e.data);
                check("ack_seen", ack_seen, e.ack);
                check("rx_valid_cycle", cyc, e.edge_n);
                $display("[TB] rx %02h ack %0d at cycle %0d", rx_data, ack_seen, cyc);
            end
        end
    end

    // Drive joy_ack low in the cycle after the given edge, for three cycles
    task automatic pulse_ack(input int after_edge);
        while (cyc < after_edge) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        joy_ack = 1'b0;
        repeat (3) @(negedge clk);
        joy_ack = 1'b1;
    endtask

    task automatic run_byte(input vec_t v);
        int guard;
        int e0;
        int s;
        int ew;
        int ed;
        exp_t e;
        @(negedge clk);
        att_en    = 1'b1;
        tx_data   = v.cmd;
        tx_valid  = 1'b1;
        dev_reply = v.reply;
        #1;
        if (!v.setup) check("att_held_low", joy_att, 1'b0);
        guard = 0;
        while (!tx_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!tx_ready) begin
            check("tx_ready_timeout", 32'd0, 32'd1);
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e0       = cyc;
        tx_valid = 1'b0;
        s        = v.setup ? ATT_SETUP : 0;
        if (!v.setup) check("b2b_handshake_edge", e0, last_done + 2);
        ew = e0 + s + 16 * HALF_DIV;
        ed = ew + ((v.ack_k >= 0 && v.ack_k < ACK_TIMEOUT) ? v.ack_k + 1 : ACK_TIMEOUT);
        e.data   = v.reply;
        e.ack    = v.exp_ack;
        e.edge_n = ed;
        sb_q.push_back(e);
        last_done = ed;
        if (v.ack_k >= 2) begin
            fork
                pulse_ack(ew + v.ack_k - 2);
            join_none
        end
        if (v.early) begin
            fork
                pulse_ack(e0 + s + 8 * HALF_DIV + 20);
            join_none
        end
        if (s > 0) begin
            while (cyc < e0 + s - 1) begin
                @(posedge clk);
                #1;
            end
            check("setup_att_clk", {joy_att, joy_clk}, 2'b01);
            @(posedge clk);
            #1;
        end
        check("first_clk_fall", joy_clk, 1'b0);
        check("cmd_bit0", joy_cmd, v.cmd[0]);
        while (cyc < ew) begin
            @(posedge clk);
            #1;
        end
        check("wait_ack_pins", {joy_clk, joy_cmd}, 2'b11);
        while (sb_q.size() != 0 && cyc < ed + 20) begin
            @(posedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            check("rx_valid_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
        check("cmd_captured", dev_cmd, v.cmd);
        $display("[TB] byte cmd %02h reply %02h ack_k %0d done", v.cmd, v.reply, v.ack_k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int rxv;
        vec_t v;

        vecs[0] = '{8'h01, 8'h41, 200,  1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h42, 8'h5A, 10,   1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'hA5, 8'h3C, -1,   1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'h00, 3299, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'hFF, 3300, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h96, 8'h69, -1,   1'b0, 1'b1, 1'b0};

        rst_n    = 1'b0;
        att_en   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        joy_ack  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_joy_clk", joy_clk, 1'b1);
        check("rst_joy_cmd", joy_cmd, 1'b1);
        check("rst_joy_att", joy_att, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_ack_seen", ack_seen, 1'b0);
        check("rst_busy", busy, 1'b0);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_att_high", joy_att, 1'b1);
        check("idle_busy", busy, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_byte(vecs[i]);
        end

        // att_en drops mid-byte: byte still completes, joy_att rises on first IDLE cycle
        fork
            begin
                repeat (300) @(negedge clk);
                att_en = 1'b0;
                repeat (5) @(negedge clk);
                check("drop_att_still_low", {joy_att, busy, tx_ready}, 3'b010);
            end
        join_none
        v = '{8'h3C, 8'hC3, 50, 1'b0, 1'b0, 1'b1};
        run_byte(v);
        check("drop_att_rises", joy_att, 1'b1);
        check("drop_tx_ready", tx_ready, 1'b0);
        check("drop_busy", busy, 1'b0);
        @(negedge clk);
        tx_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("no_accept_without_att", {busy, joy_att}, 2'b01);
        tx_valid = 1'b0;

        // Reset during bit 4 of a fresh transaction
        @(negedge clk);
        att_en    = 1'b1;
        tx_data   = 8'h5A;
        tx_valid  = 1'b1;
        dev_reply = 8'hA5;
        #1;
        check("rst_seq_tx_ready", tx_ready, 1'b1);
        @(posedge clk);
        #1;
        e0       = cyc;
        tx_valid = 1'b0;
        while (cyc < e0 + ATT_SETUP + 3 * 2 * HALF_DIV + 20) begin
            @(posedge clk);
            #1;
        end
        check("bit4_clk_low", joy_clk, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_pins", {joy_clk, joy_cmd, joy_att}, 3'b111);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_rx_valid", rx_valid, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rxv = 0;
        repeat (1500) begin
            @(negedge clk);
            if (rx_valid) rxv++;
        end
        check("no_rx_after_reset", rxv, 0);
        check("post_rst_tx_ready", tx_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_att", joy_att, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
